branch_redirect_unit: RTL and testbench
=======================================

# branch_redirect_unit

Fetch-side consumer of the EX-stage branch decision. Owns the fetch PC, advances it by 4 each cycle, and redirects it to the branch target when EX resolves a taken branch. After a redirect it squashes wrong-path instructions by driving IF/ID and ID/EX flushes for a fixed window, ignoring any branch reported from EX during that window. Sits between the EX-stage branch comparator and the IF/ID and ID/EX pipeline registers.

## Interface

Parameters:
- PC_WIDTH, 64, width of PC and target.
- RESET_PC, 64'h0, PC value loaded on reset.
- SQUASH_CYCLES, 2, length of the flush window after a redirect; legal range 1..3.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; 0 at a rising edge resets all state.
- stall  in  1  hazard-unit hold request; freezes PC when no redirect is pending.
- br_valid  in  1  EX stage holds a conditional branch this cycle.
- br_taken  in  1  branch decision from the EX comparator; qualified by br_valid.
- br_target  in  PC_WIDTH  computed branch target; qualified by br_valid & br_taken.
- pc  out  PC_WIDTH  current fetch address, registered.
- redirect  out  1  registered; high for exactly one cycle, the first cycle fetching at the new target.
- flush_ifid  out  1  registered; zero IF/ID at the next edge.
- flush_idex  out  1  registered; bubble ID/EX at the next edge.
- branch_count  out  32  only with BRANCH_STATS_EN; accepted branches.
- taken_count  out  32  only with BRANCH_STATS_EN; accepted taken branches.

## Operation

- States: RUN, SQUASH. Squash counter is 2 bits.
- Accepted branch: br_valid = 1 while state is RUN. In SQUASH, br_valid is ignored (wrong-path instruction).
- RUN, accepted branch with br_taken = 1:
  - pc <= {br_target[PC_WIDTH-1:1], 1'b0}; bit 0 is forced to zero.
  - redirect <= 1; flush_ifid <= 1; flush_idex <= 1.
  - Counter <= SQUASH_CYCLES-1; state <= SQUASH.
  - A taken branch overrides stall.
- RUN, no taken branch:
  - stall = 1 holds pc.
  - stall = 0 sets pc <= pc + 4.
  - All flushes and redirect <= 0.
- SQUASH:
  - pc <= pc + 4 every cycle; stall is ignored because the pipeline contains only bubbles.
  - redirect <= 0.
  - Flush outputs stay 1 while the counter is nonzero, and the counter decrements.
  - When the counter is 0: flushes <= 0 and state <= RUN.
  - With SQUASH_CYCLES = 1, SQUASH lasts one cycle and the unit returns to RUN directly.
- Arithmetic: pc + 4 wraps modulo 2^PC_WIDTH; no overflow flag.
- br_taken and br_target are don't-care when br_valid = 0. X on them must not propagate into pc.

## Timing

- Reset (reset = 0 at an edge):
  - pc = RESET_PC; redirect, flush_ifid, flush_idex = 0.
  - State = RUN, counter = 0, stats counters = 0.
  - Reset has priority over every other event, including mid-SQUASH; no residual flush is driven afterwards.
- Latency: a taken branch sampled at edge E gives pc = target in cycle E+1, with redirect high in E+1 only.
- flush_ifid and flush_idex are high for exactly SQUASH_CYCLES cycles, E+1 through E+SQUASH_CYCLES.
- The first branch accepted after a redirect is the one sampled at edge E+SQUASH_CYCLES+1.
- A not-taken branch has zero cost: pc advances normally, no flush.
- A taken branch at the same edge as stall = 1: the redirect is taken and the stall is dropped.
- Back-to-back taken branches in consecutive EX cycles: the second is masked by SQUASH, as required.

## Configuration

- BRANCH_STATS_EN defined:
  - branch_count increments on every accepted branch.
  - taken_count increments on every accepted taken branch.
  - Both are 32-bit, wrap at 2^32, cleared by reset, and do not count masked (SQUASH) branches.
- BRANCH_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan

- Reset with RESET_PC = 0: hold reset = 0 for 2 cycles, then release. pc = 0 during reset, then 4, 8, 12 on successive cycles; all flushes 0.
- Taken redirect: with pc = 0x10, drive br_valid = 1, br_taken = 1, br_target = 0x101. Next cycle pc = 0x100 with redirect = 1 and flushes = 1; the following cycle pc = 0x104, flushes = 1, redirect = 0; next cycle pc = 0x108, flushes = 0.
- Masking and stall: a taken branch to 0x200, then br_valid = 1, br_taken = 1, br_target = 0x300 on the next 2 cycles. Both are ignored: pc runs 0x200, 0x204, 0x208. Then stall = 1 for 3 cycles holds pc at 0x20C.
- Priority and wrap: stall = 1 together with a taken branch to 0x40 gives pc = 0x40. pc = 64'hFFFF_FFFF_FFFF_FFFC with no branch gives next pc = 0.
- Reset mid-SQUASH: drive reset = 0 in the cycle after a redirect. Next cycle flushes = 0 and pc = RESET_PC; a branch one cycle after reset release is accepted.
- BRANCH_STATS_EN: 5 accepted branches, 3 of them taken, plus 2 branches masked during SQUASH. Expect branch_count = 5 and taken_count = 3.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: advances by 4, redirects on EX-resolved taken branches and
// squashes the wrong path. Optional accepted/taken counters under BRANCH_STATS_EN.
//
// state  | meaning
// RUN    | normal fetch; EX branches are accepted
// SQUASH | flush window after a redirect; EX branches are wrong-path and ignored
module branch_redirect_unit #(
  parameter int unsigned         PC_WIDTH      = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned         SQUASH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
`ifdef BRANCH_STATS_EN
  output logic [31:0]         branch_count,
  output logic [31:0]         taken_count,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic                redirect,
  output logic                flush_ifid,
  output logic                flush_idex
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [1:0]          SQ_LOAD    = 2'(SQUASH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(1);

  state_t     state;
  logic [1:0] cnt;
  logic       take;

  // A branch only counts while in RUN; during SQUASH it is a wrong-path instruction.
  assign take = (state == RUN) && br_valid && br_taken;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= '0;
      pc         <= RESET_PC;
      redirect   <= 1'b0;
      flush_ifid <= 1'b0;
      flush_idex <= 1'b0;
    end else begin
      redirect <= 1'b0;
      if (state == RUN) begin
        if (take) begin
          pc         <= br_target & ALIGN_MASK;
          redirect   <= 1'b1;
          flush_ifid <= 1'b1;
          flush_idex <= 1'b1;
          cnt        <= SQ_LOAD;
          state      <= SQUASH;
        end else begin
          if (!stall) pc <= pc + PC_STEP;
          flush_ifid <= 1'b0;
          flush_idex <= 1'b0;
        end
      end else begin
        pc <= pc + PC_STEP;
        if (cnt != 2'd0) begin
          cnt <= cnt - 2'd1;
        end else begin
          flush_ifid <= 1'b0;
          flush_idex <= 1'b0;
          state      <= RUN;
        end
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (state == RUN && br_valid) begin
      branch_count <= branch_count + 32'd1;
      if (br_taken) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios with literal expectations,
// then random traffic checked every cycle against a window-countdown model.
module tb_branch_redirect_unit;
  localparam int unsigned PW = 64;
  localparam int unsigned SQ = 2;
  localparam logic [PW-1:0] RPC = 64'h0;

  logic clk = 1'b0;
  logic reset, stall, br_valid, br_taken;
  logic [PW-1:0] br_target;
  logic [PW-1:0] pc;
  logic redirect, flush_ifid, flush_idex;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count, taken_count;
`endif

  branch_redirect_unit #(.PC_WIDTH(PW), .RESET_PC(RPC), .SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target),
`ifdef BRANCH_STATS_EN
    .branch_count(branch_count), .taken_count(taken_count),
`endif
    .pc(pc), .redirect(redirect), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: m_rem = remaining cycles of the masked/flush window.
  logic [PW-1:0] m_pc;
  logic          m_red;
  int            m_rem;
  logic [31:0]   m_b, m_t;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc <= RPC; m_red <= 1'b0; m_rem <= 0; m_b <= 0; m_t <= 0;
    end else if (m_rem > 0) begin
      m_pc <= m_pc + 64'd4; m_red <= 1'b0; m_rem <= m_rem - 1;
    end else begin
      if (br_valid) begin
        m_b <= m_b + 1;
        if (br_taken) m_t <= m_t + 1;
      end
      if (br_valid && br_taken) begin
        m_pc <= {br_target[PW-1:1], 1'b0}; m_red <= 1'b1; m_rem <= SQ;
      end else begin
        m_red <= 1'b0;
        if (!stall) m_pc <= m_pc + 64'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_pc", pc, m_pc);
      chk("model_redirect", 64'(redirect), 64'(m_red));
      chk("model_flush_ifid", 64'(flush_ifid), 64'(m_rem > 0));
      chk("model_flush_idex", 64'(flush_idex), 64'(m_rem > 0));
`ifdef BRANCH_STATS_EN
      chk("model_branch_count", 64'(branch_count), 64'(m_b));
      chk("model_taken_count", 64'(taken_count), 64'(m_t));
`endif
    end
  end

  // Called at a negedge: apply inputs, pass one rising edge, return at the next negedge.
  task automatic cyc(input logic r, input logic s, input logic v, input logic t,
                     input logic [PW-1:0] tgt);
    reset = r; stall = s; br_valid = v; br_taken = t; br_target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [63:0] epc, input logic ered,
                     input logic efl);
    chk({name, "_pc"}, pc, epc);
    chk({name, "_redirect"}, 64'(redirect), 64'(ered));
    chk({name, "_flush"}, 64'({flush_ifid, flush_idex}), 64'({efl, efl}));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    lit("reset1", 64'h0, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0);  lit("reset2", 64'h0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);  lit("run4", 64'h4, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);  lit("run8", 64'h8, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);  lit("run12", 64'hC, 1'b0, 1'b0);
    cyc(1, 0, 1, 0, 64'h999); lit("not_taken", 64'h10, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 64'h101); lit("redir", 64'h100, 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0);  lit("squash1", 64'h104, 1'b0, 1'b1);
    cyc(1, 0, 0, 0, 0);  lit("squash_end", 64'h108, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 64'h200); lit("redir200", 64'h200, 1'b1, 1'b1);
    cyc(1, 0, 1, 1, 64'h300); lit("mask1", 64'h204, 1'b0, 1'b1);
    cyc(1, 0, 1, 1, 64'h300); lit("mask2", 64'h208, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);  lit("pre_stall", 64'h20C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0); lit("stall_hold", 64'h20C, 1'b0, 1'b0);
    end
    cyc(1, 1, 1, 1, 64'h40); lit("stall_prio", 64'h40, 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);  lit("after_prio", 64'h48, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC); lit("to_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0);  lit("wrap", 64'h0, 1'b0, 1'b1);
    cyc(1, 0, 0, 0, 0);  lit("after_wrap", 64'h4, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 64'h500); lit("redir500", 64'h500, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 0);  lit("reset_mid_squash", RPC, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);  lit("post_reset", 64'h4, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 64'h601); lit("accept_after_reset", 64'h600, 1'b1, 1'b1);
`ifdef BRANCH_STATS_EN
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 64'h1);
    cyc(1, 0, 1, 1, 64'h800);
    cyc(1, 0, 1, 1, 64'h900);
    cyc(1, 0, 1, 0, 64'h900);
    cyc(1, 0, 1, 0, 64'h0);
    cyc(1, 0, 1, 1, 64'hA00);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 64'hB00);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("stats_branch_count", 64'(branch_count), 64'd5);
    chk("stats_taken_count", 64'(taken_count), 64'd3);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [PW-1:0] tg;
      tg = {$urandom, $urandom};
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, tg);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
